// File: rtl/matrix_pkg.sv
// matrix_pkg: shared definitions for the matrix MEM-stage sequencer.
//   MAT_W  - matrix operand width (bits)
//   WORD_W - data-memory word width (bits)
//   BEATS  - number of word transfers per matrix operand
//   mat_state_e - sequencer FSM states
//   mat_op_e    - captured operation kind
package matrix_pkg;

  localparam int unsigned MAT_W  = 128;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BEATS  = MAT_W / WORD_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    FIN    = 2'd2
  } mat_state_e;

  typedef enum logic {
    OP_STORE = 1'b0,
    OP_LOAD  = 1'b1
  } mat_op_e;

endpackage

// File: rtl/mat_beat_buffer.sv
// mat_beat_buffer: matrix-wide register split into word lanes.
//   A full-width capture loads the store operand; a word write gathers load
//   beats one lane at a time; a word read mux feeds the store beats.
// Ports:
//   clk, rst        - clock, synchronous active-low reset
//   cap_en/cap_data - load the whole register (takes priority over wr_en)
//   wr_en/wr_idx/wr_word - write one word lane
//   rd_idx/rd_word  - combinational word read of the current contents
//   buf_next        - next-state value (current contents plus this cycle's write)
module mat_beat_buffer #(
  parameter int unsigned MAT_W  = 128,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_en,
  input  logic [MAT_W-1:0]  cap_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WORD_W-1:0] wr_word,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [WORD_W-1:0] rd_word,
  output logic [MAT_W-1:0]  buf_next
);

  localparam int unsigned NUM_WORDS = MAT_W / WORD_W;

  logic [NUM_WORDS-1:0][WORD_W-1:0] buf_q;
  logic [NUM_WORDS-1:0][WORD_W-1:0] buf_d;

  always_comb begin
    buf_d = buf_q;
    if (cap_en) begin
      buf_d = cap_data;
    end else if (wr_en) begin
      buf_d[wr_idx] = wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_q <= '0;
    end else begin
      buf_q <= buf_d;
    end
  end

  assign rd_word  = buf_q[rd_idx];
  // Exposed so the final gathered beat lands in load_data on the same edge.
  assign buf_next = buf_d;

endmodule

// File: rtl/matrix_mem_sequencer.sv
// matrix_mem_sequencer: MEM-stage sequencer moving matrix operands between the
// EX/MEM register and a word-wide data memory, one word beat at a time, while
// stalling the upstream pipeline.
// Optional feature macro: MATRIX_LOAD_EN (enables the matrix load path; without
// it only stores are sequenced and the load outputs are tied to zero).
// Ports:
//   clk, rst            - clock, synchronous active-low reset
//   me_mat_store/load   - MEM-stage matrix store / load request
//   me_addr             - base byte address (low two bits ignored)
//   me_matrix_data      - store operand
//   me_rd               - load destination register
//   dmem_req/we/addr/wdata - registered data-memory beat request
//   dmem_rdata/ready    - memory response; ready accepts/completes the beat
//   stall               - freeze IF/ID, ID/EX, EX/MEM (combinational in IDLE)
//   busy                - transfer in progress (ACCESS or FIN)
//   done                - one-cycle completion pulse
//   load_valid/data/rd  - completed load result, held until the next load
module matrix_mem_sequencer #(
  parameter int unsigned MAT_W  = matrix_pkg::MAT_W,
  parameter int unsigned WORD_W = matrix_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              me_mat_store,
  input  logic              me_mat_load,
  input  logic [31:0]       me_addr,
  input  logic [MAT_W-1:0]  me_matrix_data,
  input  logic [4:0]        me_rd,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [31:0]       dmem_addr,
  output logic [WORD_W-1:0] dmem_wdata,
  input  logic [WORD_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  output logic              stall,
  output logic              busy,
  output logic              done,
  output logic              load_valid,
  output logic [MAT_W-1:0]  load_data,
  output logic [4:0]        load_rd
);

  import matrix_pkg::*;

  localparam int unsigned NUM_BEATS = MAT_W / WORD_W;
  localparam int unsigned BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

  mat_state_e        state_q;
  logic [BEAT_W-1:0] beat_q;
  logic [BEAT_W-1:0] beat_inc;

  logic              store_trig;
  logic              load_trig;
  logic              trigger;
  logic              capture;
  logic              last_step;
  logic              gather_en;
  logic [WORD_W-1:0] next_word;
  logic [MAT_W-1:0]  buf_next;

  assign store_trig = me_mat_store;
  assign trigger    = store_trig | load_trig;
  assign capture    = (state_q == IDLE) && trigger;
  assign last_step  = (state_q == ACCESS) && dmem_ready && (beat_q == LAST_BEAT);
  assign beat_inc   = beat_q + 1'b1;

  // Combinational so the stall reaches the pipeline in the trigger cycle itself.
  assign stall = capture || (state_q == ACCESS);

  // ---------------------------------------------------------------------------
  // Main FSM with registered memory-side outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (trigger) begin
            state_q    <= ACCESS;
            beat_q     <= '0;
            busy       <= 1'b1;
            dmem_req   <= 1'b1;
            // Store wins over a simultaneous load.
            dmem_we    <= store_trig;
            dmem_addr  <= {me_addr[31:2], 2'b00};
            dmem_wdata <= me_matrix_data[WORD_W-1:0];
          end
        end
        ACCESS: begin
          // Without ready every output holds its value.
          if (dmem_ready) begin
            if (beat_q == LAST_BEAT) begin
              state_q  <= FIN;
              dmem_req <= 1'b0;
              dmem_we  <= 1'b0;
              done     <= 1'b1;
            end else begin
              beat_q     <= beat_inc;
              dmem_addr  <= dmem_addr + 32'd4;
              dmem_wdata <= next_word;
            end
          end
        end
        FIN: begin
          // EX/MEM advances on this edge; the stale request is not re-sampled.
          state_q <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Operand buffer: store source and load gather
  // ---------------------------------------------------------------------------
  mat_beat_buffer #(
    .MAT_W  (MAT_W),
    .WORD_W (WORD_W),
    .IDX_W  (BEAT_W)
  ) u_beat_buffer (
    .clk      (clk),
    .rst      (rst),
    .cap_en   (capture),
    .cap_data (me_matrix_data),
    .wr_en    (gather_en),
    .wr_idx   (beat_q),
    .wr_word  (dmem_rdata),
    .rd_idx   (beat_inc),
    .rd_word  (next_word),
    .buf_next (buf_next)
  );

  // ---------------------------------------------------------------------------
  // Load path
  // ---------------------------------------------------------------------------
`ifdef MATRIX_LOAD_EN
  mat_op_e    op_q;
  logic [4:0] rd_q;

  assign load_trig = me_mat_load & ~me_mat_store;
  assign gather_en = (state_q == ACCESS) && dmem_ready && (op_q == OP_LOAD);

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q       <= OP_STORE;
      rd_q       <= '0;
      load_valid <= 1'b0;
      load_data  <= '0;
      load_rd    <= '0;
    end else begin
      load_valid <= 1'b0;
      if (capture) begin
        op_q <= store_trig ? OP_STORE : OP_LOAD;
        rd_q <= me_rd;
      end
      if (last_step && (op_q == OP_LOAD)) begin
        load_valid <= 1'b1;
        load_data  <= buf_next;
        load_rd    <= rd_q;
      end
    end
  end

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^me_addr[1:0];
`else
  assign load_trig  = 1'b0;
  assign gather_en  = 1'b0;
  assign load_valid = 1'b0;
  assign load_data  = '0;
  assign load_rd    = '0;

  logic unused_load_path;
  assign unused_load_path = ^{me_mat_load, me_rd, buf_next, last_step, me_addr[1:0]};
`endif

endmodule

// File: tb/tb_matrix_mem_sequencer.sv
module tb_matrix_mem_sequencer;

  localparam int unsigned MAT_W  = 128;
  localparam int unsigned WORD_W = 32;
`ifdef MATRIX_LOAD_EN
  localparam bit LOAD_EN = 1'b1;
`else
  localparam bit LOAD_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              me_mat_store, me_mat_load;
  logic [31:0]       me_addr;
  logic [MAT_W-1:0]  me_matrix_data;
  logic [4:0]        me_rd;
  logic              dmem_req, dmem_we;
  logic [31:0]       dmem_addr;
  logic [WORD_W-1:0] dmem_wdata, dmem_rdata;
  logic              dmem_ready;
  logic              stall, busy, done, load_valid;
  logic [MAT_W-1:0]  load_data;
  logic [4:0]        load_rd;

  matrix_mem_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .me_mat_store   (me_mat_store),
    .me_mat_load    (me_mat_load),
    .me_addr        (me_addr),
    .me_matrix_data (me_matrix_data),
    .me_rd          (me_rd),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_rdata     (dmem_rdata),
    .dmem_ready     (dmem_ready),
    .stall          (stall),
    .busy           (busy),
    .done           (done),
    .load_valid     (load_valid),
    .load_data      (load_data),
    .load_rd        (load_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    bit           is_load;
    logic [127:0] data;
    logic [4:0]   rd;
  } cmpl_t;

  beat_t       exp_beats[$];
  cmpl_t       exp_cmpl[$];
  bit          ready_plan[$];
  bit          rand_ready = 1'b0;
  logic [31:0] dut_mem[bit [31:0]];
  logic [31:0] ref_mem[bit [31:0]];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'h5a5a_0f0f;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] dut_rd(input logic [31:0] a);
    return dut_mem.exists(a) ? dut_mem[a] : init_word(a);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input logic [127:0] act);
    checks++;
    errors++;
    $display("FAIL %s: observed %0h (t=%0t)", name, act, $time);
  endtask

  // Memory responder: ready from the plan queue, then random or always-ready.
  initial begin
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (dmem_req === 1'b1) begin
        if (ready_plan.size() > 0) dmem_ready = ready_plan.pop_front();
        else if (rand_ready)       dmem_ready = ($urandom_range(0, 3) != 0);
        else                       dmem_ready = 1'b1;
        dmem_rdata = dut_rd(dmem_addr);
      end else begin
        dmem_ready = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    beat_t        b;
    cmpl_t        c;
    int           stall_cnt = 0;
    int           low_cnt   = 0;
    int           txn_cyc   = 0;
    bit           active    = 1'b0;
    logic [127:0] last_data = '0;
    logic [4:0]   last_rd   = '0;
    forever begin
      @(negedge clk);
      // Beats are accepted even in a cycle where reset is being asserted.
      if (dmem_req === 1'b1 && dmem_ready) begin
        if (exp_beats.size() == 0) begin
          fail("unexpected_beat", dmem_addr);
        end else begin
          b = exp_beats.pop_front();
          check("beat_addr", dmem_addr, b.addr);
          check("beat_we", dmem_we, b.we);
          if (b.we) check("beat_wdata", dmem_wdata, b.wdata);
        end
        if (dmem_we) dut_mem[dmem_addr] = dmem_wdata;
      end
      if (!rst) begin
        stall_cnt = 0;
        low_cnt   = 0;
        txn_cyc   = 0;
        active    = 1'b0;
        last_data = '0;
        last_rd   = '0;
      end else begin
        if (stall) begin
          stall_cnt++;
          active = 1'b1;
        end
        if (active) txn_cyc++;
        if (dmem_req === 1'b1 && !dmem_ready) low_cnt++;
        if (done) begin
          if (exp_cmpl.size() == 0) begin
            fail("unexpected_done", done);
          end else begin
            c = exp_cmpl.pop_front();
            check("stall_cycles", stall_cnt, 5 + low_cnt);
            check("done_latency", txn_cyc, 6 + low_cnt);
            check("stall_at_done", stall, 1'b0);
            check("req_at_done", dmem_req, 1'b0);
            check("busy_at_done", busy, 1'b1);
            check("beats_left", exp_beats.size(), 0);
            check("load_valid", load_valid, c.is_load);
            if (c.is_load) begin
              last_data = c.data;
              last_rd   = c.rd;
            end
            check("load_data", load_data, last_data);
            check("load_rd", load_rd, last_rd);
          end
          stall_cnt = 0;
          low_cnt   = 0;
          txn_cyc   = 0;
          active    = 1'b0;
        end else if (load_valid) begin
          fail("load_valid_without_done", load_valid);
        end
      end
    end
  end

  // Called at posedge+1 in IDLE; returns at posedge+1 with requests dropped.
  task automatic issue(input bit st, input bit ld, input logic [31:0] addr,
                       input logic [127:0] data, input logic [4:0] rd);
    bit           do_store, do_load;
    logic [31:0]  base, a;
    logic [127:0] ld_data;
    cmpl_t        c;
    int           n;
    do_store = st;
    do_load  = !st && ld && LOAD_EN;
    base     = {addr[31:2], 2'b00};
    ld_data  = '0;
    me_mat_store   = st;
    me_mat_load    = ld;
    me_addr        = addr;
    me_matrix_data = data;
    me_rd          = rd;
    if (do_store || do_load) begin
      for (int i = 0; i < 4; i++) begin
        a = base + 32'(4 * i);
        if (do_store) begin
          ref_mem[a] = data[i*32 +: 32];
          exp_beats.push_back('{a, 1'b1, data[i*32 +: 32]});
        end else begin
          ld_data[i*32 +: 32] = ref_rd(a);
          exp_beats.push_back('{a, 1'b0, 32'h0});
        end
      end
      c.is_load = do_load;
      c.data    = ld_data;
      c.rd      = rd;
      exp_cmpl.push_back(c);
    end
    @(negedge clk);
    check("stall_on_trigger", stall, do_store || do_load);
    if (do_store || do_load) begin
      n = 0;
      while (!done && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("done_seen", done, 1'b1);
    end else begin
      repeat (3) begin
        @(negedge clk);
        check("ignored_req", dmem_req, 1'b0);
        check("ignored_stall", stall, 1'b0);
      end
    end
    @(posedge clk);
    #1;
    me_mat_store = 1'b0;
    me_mat_load  = 1'b0;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    dut_mem[a] = v;
    ref_mem[a] = v;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]  addr;
    logic [127:0] data;
    int           r;
    rst            = 1'b0;
    me_mat_store   = 1'b0;
    me_mat_load    = 1'b0;
    me_addr        = '0;
    me_matrix_data = '0;
    me_rd          = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dmem_req", dmem_req, 1'b0);
    check("rst_dmem_we", dmem_we, 1'b0);
    check("rst_dmem_addr", dmem_addr, 32'h0);
    check("rst_dmem_wdata", dmem_wdata, 32'h0);
    check("rst_stall", stall, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_load_valid", load_valid, 1'b0);
    check("rst_load_data", load_data, 128'h0);
    check("rst_load_rd", load_rd, 5'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic store, always ready.
    issue(1'b1, 1'b0, 32'h100, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 5'd0);
    // Ready low for two cycles on beat 1.
    ready_plan = '{1'b1, 1'b0, 1'b0};
    issue(1'b1, 1'b0, 32'h100, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 5'd0);
    // Load (ignored without the load path).
    preload(32'h200, 32'h11111111);
    preload(32'h204, 32'h22222222);
    preload(32'h208, 32'h33333333);
    preload(32'h20C, 32'h44444444);
    issue(1'b0, 1'b1, 32'h200, 128'h0, 5'd5);
    // Address wrap at the top of memory.
    issue(1'b1, 1'b0, 32'hFFFFFFF9, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 5'd0);
    // Store and load together: store wins.
    issue(1'b1, 1'b1, 32'h400, 128'hCAFEF00D_DEADBEEF_0BADC0DE_12345678, 5'd7);

    // Reset during beat 2: beats 0..2 reach memory, no completion.
    me_mat_store   = 1'b1;
    me_addr        = 32'h500;
    me_matrix_data = 128'h44440000_33330000_22220000_11110000;
    for (int i = 0; i < 3; i++) begin
      ref_mem[32'h500 + 32'(4 * i)] = me_matrix_data[i*32 +: 32];
      exp_beats.push_back('{32'h500 + 32'(4 * i), 1'b1, me_matrix_data[i*32 +: 32]});
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst          = 1'b0;
    me_mat_store = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("midrst_req", dmem_req, 1'b0);
    check("midrst_stall", stall, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_beats_left", exp_beats.size(), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    issue(1'b1, 1'b0, 32'h600, 128'h0F0F0F0F_F0F0F0F0_AAAA5555_5555AAAA, 5'd0);

    // Randomized traffic.
    rand_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 3);
      unique case (r)
        0:       addr = $urandom;
        1:       addr = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
        default: addr = 32'h1000 + 32'($urandom_range(0, 63));
      endcase
      data = {$urandom, $urandom, $urandom, $urandom};
      r = $urandom_range(0, 3);
      issue(r != 1, r == 1 || r == 2, addr, data, 5'($urandom_range(0, 31)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (4) @(negedge clk);
    check("drain_beats", exp_beats.size(), 0);
    check("drain_cmpl", exp_cmpl.size(), 0);
    check("idle_busy", busy, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_mem_sequencer.md
# matrix_mem_sequencer

MEM-stage sequencer that moves 128-bit matrix operands between the EX/MEM pipeline register and the 32-bit data memory. A matrix store is split into four 32-bit word writes; a matrix load is assembled from four word reads. While a transfer is in progress, the block stalls the upstream pipeline registers (IF/ID, ID/EX, EX/MEM).

## Interface
Parameters:
- MAT_W, 128, matrix operand width
- WORD_W, 32, data-memory word width; BEATS = MAT_W/WORD_W (4)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- me_mat_store  in  1  MEM-stage instruction is a matrix store
- me_mat_load  in  1  MEM-stage instruction is a matrix load
- me_addr  in  32  base byte address (ALU result)
- me_matrix_data  in  MAT_W  store data (EX/MEM matrix result)
- me_rd  in  5  load destination register
- dmem_req  out  1  memory access valid
- dmem_we  out  1  write enable
- dmem_addr  out  32  word byte address
- dmem_wdata  out  WORD_W  write data
- dmem_rdata  in  WORD_W  read data, valid with dmem_ready
- dmem_ready  in  1  beat accepted/completed this cycle
- stall  out  1  freeze upstream pipeline registers
- busy  out  1  FSM not IDLE
- done  out  1  one-cycle pulse, transfer complete
- load_valid  out  1  one-cycle pulse, load_data/load_rd valid
- load_data  out  MAT_W  assembled matrix
- load_rd  out  5  captured me_rd

## Operation
- FSM states: IDLE, ACCESS, FIN.
- IDLE: a trigger is me_mat_store or me_mat_load. On a trigger, the block captures base = {me_addr[31:2],2'b00}, the data, the rd and the op (store wins if both are set; the load is dropped). It then clears beat and moves to ACCESS.
- ACCESS: dmem_req=1, dmem_we=op_store, dmem_addr=base+4*beat (mod 2^32), dmem_wdata=data[beat*32 +: 32].
  - On dmem_ready in a load, load_buf[beat*32 +: 32] <= dmem_rdata.
  - On dmem_ready with beat==BEATS-1, go to FIN. Otherwise beat++.
  - Without dmem_ready, hold all outputs.
- FIN: done=1. For a load, load_valid=1 and load_data/load_rd are updated. stall=0 so EX/MEM advances at the clock edge. Always go to IDLE; the stale me_* inputs in FIN never retrigger.
- stall = (IDLE & trigger) | ACCESS. It is combinational in IDLE.
- load_data and load_rd hold until the next load completes.
- Partially written memory is never rolled back.
- Reset: state=IDLE, beat=0. All outputs are 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, stall, busy, done, load_valid, load_data, load_rd.
- Reset mid-transfer: the next cycle is IDLE with dmem_req=0 and stall=0. No done pulse is produced.

## Timing
- Trigger seen at cycle T (IDLE), with dmem_ready held high:
  - Beats occur at T+1 through T+4.
  - FIN is at T+5.
  - stall is high T..T+4, which is 5 cycles.
  - done and load_valid are high at T+5.
- Each cycle with dmem_ready low during ACCESS adds exactly one stall cycle.
- dmem_* outputs are registered. Only stall is combinational, from me_mat_store/me_mat_load in IDLE.
- busy is high in ACCESS and FIN.

## Configuration
- MATRIX_LOAD_EN defined:
  - Load path is present: load_buf, load_valid, load_data, load_rd.
  - me_mat_load triggers a transfer.
- MATRIX_LOAD_EN undefined:
  - me_mat_load is ignored, so no stall is raised for it.
  - dmem_we=1 on every beat.
  - load_valid, load_data and load_rd are tied to 0.

## Structure
- Shared package matrix_pkg holds:
  - MAT_W, WORD_W, BEATS
  - the state enum {IDLE, ACCESS, FIN}
  - the op encoding
- One sub-module, mat_beat_buffer: a 128-bit register with a beat-indexed word read mux (store) and a word write (load gather).
- The FSM, address generation and stall logic stay in the top level.

## Test plan
- Store at base 0x100 with data 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA and ready=1:
  - Expected writes: 0x100:AAAAAAAA, 0x104:BBBBBBBB, 0x108:CCCCCCCC, 0x10C:DDDDDDDD.
  - stall high 5 cycles, done at T+5.
- Store with ready low for 2 cycles on beat 1:
  - dmem_addr=0x104 and wdata=BBBBBBBB are held.
  - stall is 7 cycles.
- Load (MATRIX_LOAD_EN) at base 0x200 with me_rd=5:
  - rdata sequence: 0x11111111, 0x22222222, 0x33333333, 0x44444444.
  - Expected: load_data=0x44444444_33333333_22222222_11111111, load_rd=5, load_valid pulse at T+5.
- Store at base 0xFFFFFFF9:
  - Expected addresses: 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- Reset (rst=0) asserted during beat 2:
  - Next cycle: dmem_req=0, stall=0, busy=0, no done.
  - A subsequent store runs normally.
- me_mat_store=me_mat_load=1:
  - A store is performed and load_valid stays 0.
- Without MATRIX_LOAD_EN, a load request produces no stall and no dmem_req.
